goertzel_bank: RTL and testbench

Time-multiplexed, parametrised Goertzel filter bank for the note-detection path. Accepts a stream of signed audio samples and runs one shared recurrence datapath across `NUM_BINS` frequency bins. Each bin's coefficient is loaded at runtime. At the end of each block of `block_len` samples, the bank emits one squared-magnitude power word per bin as a sequential stream for the detector. It replaces per-bin fixed-coefficient filter instances.

---
 rtl/goertzel_pkg.sv | 26 ++
 rtl/goertzel_bank_if.sv | 31 +++
 rtl/goertzel_power_calc.sv | 42 ++++
 rtl/goertzel_bank.sv | 97 +++++++++
 tb/tb_goertzel_bank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/goertzel_pkg.sv
// goertzel_pkg: shared defaults, state encoding and saturation helpers for goertzel_bank
package goertzel_pkg;
  localparam int D_NUM_BINS = 4;
  localparam int D_SAMPLE_W = 24;
  localparam int D_COEFF_W = 26;
  localparam int D_COEFF_FRAC = 23;
  localparam int D_STATE_W = 48;
  localparam int D_POWER_W = 64;
  localparam int D_MAX_BLOCK_LEN = 1024;
  localparam int WIDE = 128;
  typedef logic signed [WIDE-1:0] wide_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UPDATE = 2'd1;
  localparam logic [1:0] POWER = 2'd2;
  function automatic wide_t sat_s(wide_t v, int w);
    wide_t hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    return v > hi ? hi : v < ~hi ? ~hi : v;
  endfunction
  function automatic wide_t clamp_u(wide_t v, int w);
    wide_t hi = (wide_t'(1) <<< w) - wide_t'(1);
    return v[WIDE-1] ? '0 : v > hi ? hi : v;
  endfunction
  function automatic wide_t cs_term(wide_t c, wide_t s, int frac);
    return (c * s) >>> frac;
  endfunction
endpackage

// File: rtl/goertzel_bank_if.sv
// goertzel_bank_if: sample, coefficient and power bus between a source and goertzel_bank
interface goertzel_bank_if import goertzel_pkg::*; #(
  parameter int NUM_BINS = D_NUM_BINS,
  parameter int SAMPLE_W = D_SAMPLE_W,
  parameter int COEFF_W = D_COEFF_W,
  parameter int POWER_W = D_POWER_W,
  parameter int MAX_BLOCK_LEN = D_MAX_BLOCK_LEN,
  parameter int BIN_W = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1,
  parameter int LEN_W = $clog2(MAX_BLOCK_LEN + 1)
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic sample_valid;
  logic sample_ready;
  logic [LEN_W-1:0] block_len;
  logic coeff_we;
  logic [BIN_W-1:0] coeff_addr;
  logic signed [COEFF_W-1:0] coeff_wdata;
  logic [POWER_W-1:0] power_out;
  logic power_valid;
  logic [BIN_W-1:0] power_bin;
  logic power_last;
  logic busy;
  modport master(
    output sample_in, sample_valid, block_len, coeff_we, coeff_addr, coeff_wdata,
    input sample_ready, power_out, power_valid, power_bin, power_last, busy
  );
  modport slave(
    input sample_in, sample_valid, block_len, coeff_we, coeff_addr, coeff_wdata,
    output sample_ready, power_out, power_valid, power_bin, power_last, busy
  );
endinterface

// File: rtl/goertzel_power_calc.sv
// goertzel_power_calc: clamped bin power from final states, registered onto the output stream
module goertzel_power_calc import goertzel_pkg::*; #(
  parameter int COEFF_W = D_COEFF_W,
  parameter int COEFF_FRAC = D_COEFF_FRAC,
  parameter int STATE_W = D_STATE_W,
  parameter int POWER_W = D_POWER_W,
  parameter int BIN_W = 2
) (
  input logic clk,
  input logic reset,
  input logic en,
  input logic last,
  input logic [BIN_W-1:0] bin,
  input logic signed [COEFF_W-1:0] c,
  input logic signed [STATE_W-1:0] s1,
  input logic signed [STATE_W-1:0] s2,
  output logic [POWER_W-1:0] power_out,
  output logic power_valid,
  output logic [BIN_W-1:0] power_bin,
  output logic power_last
);
  wide_t w1, w2, wc;
  always_comb begin
    w1 = wide_t'(s1);
    w2 = wide_t'(s2);
    wc = wide_t'(c);
  end
  always_ff @(posedge clk)
    if (reset) begin
      power_out <= '0;
      power_valid <= 1'b0;
      power_bin <= '0;
      power_last <= 1'b0;
    end else begin
      power_valid <= en;
      power_last <= en && last;
      if (en) begin
        power_out <= POWER_W'(clamp_u(w1 * w1 + w2 * w2 - cs_term(wc, w1, COEFF_FRAC) * w2, POWER_W));
        power_bin <= bin;
      end
    end
endmodule

// File: rtl/goertzel_bank.sv
// goertzel_bank: time-multiplexed Goertzel filter bank emitting per-bin block power
module goertzel_bank import goertzel_pkg::*; #(
  parameter int NUM_BINS = D_NUM_BINS,
  parameter int SAMPLE_W = D_SAMPLE_W,
  parameter int COEFF_W = D_COEFF_W,
  parameter int COEFF_FRAC = D_COEFF_FRAC,
  parameter int STATE_W = D_STATE_W,
  parameter int POWER_W = D_POWER_W,
  parameter int MAX_BLOCK_LEN = D_MAX_BLOCK_LEN
) (
  input logic clk,
  input logic reset,
  goertzel_bank_if.slave bus
);
  localparam int BIN_W = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1;
  localparam int LEN_W = $clog2(MAX_BLOCK_LEN + 1);
  logic [1:0] state;
  logic [BIN_W-1:0] k;
  logic [LEN_W-1:0] cnt, len, len_in;
  logic signed [SAMPLE_W-1:0] x;
  logic signed [COEFF_W-1:0] cs [NUM_BINS];
  logic signed [COEFF_W-1:0] ca [NUM_BINS];
  logic signed [STATE_W-1:0] s1 [NUM_BINS];
  logic signed [STATE_W-1:0] s2 [NUM_BINS];
  logic signed [STATE_W-1:0] s0;
  logic acc, last_k;
  assign bus.sample_ready = state == IDLE && !reset;
  assign bus.busy = cnt != '0 || state != IDLE;
  always_comb begin
    acc = bus.sample_valid && bus.sample_ready;
    last_k = 32'(k) == NUM_BINS - 1;
    len_in = bus.block_len < LEN_W'(2) ? LEN_W'(2) : 32'(bus.block_len) > MAX_BLOCK_LEN ? LEN_W'(MAX_BLOCK_LEN) : bus.block_len;
    s0 = STATE_W'(sat_s(wide_t'(x) + cs_term(wide_t'(ca[k]), wide_t'(s1[k]), COEFF_FRAC) - wide_t'(s2[k]), STATE_W));
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      k <= '0;
      cnt <= '0;
      len <= '0;
      x <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        cs[i] <= '0;
        ca[i] <= '0;
        s1[i] <= '0;
        s2[i] <= '0;
      end
    end else begin
      if (bus.coeff_we && 32'(bus.coeff_addr) < NUM_BINS)
        cs[bus.coeff_addr] <= bus.coeff_wdata;
      if (acc) begin
        state <= UPDATE;
        x <= bus.sample_in;
        cnt <= cnt + LEN_W'(1);
        if (cnt == '0) begin
          ca <= cs;
          len <= len_in;
        end
      end
      if (state == UPDATE) begin
        s1[k] <= s0;
        s2[k] <= s1[k];
        k <= last_k ? '0 : k + BIN_W'(1);
        if (last_k)
          state <= cnt == len ? POWER : IDLE;
      end
      if (state == POWER) begin
        s1[k] <= '0;
        s2[k] <= '0;
        k <= last_k ? '0 : k + BIN_W'(1);
        if (last_k) begin
          state <= IDLE;
          cnt <= '0;
        end
      end
    end
  goertzel_power_calc #(
    .COEFF_W(COEFF_W),
    .COEFF_FRAC(COEFF_FRAC),
    .STATE_W(STATE_W),
    .POWER_W(POWER_W),
    .BIN_W(BIN_W)
  ) u_pwr (
    .clk(clk),
    .reset(reset),
    .en(state == POWER),
    .last(last_k),
    .bin(k),
    .c(ca[k]),
    .s1(s1[k]),
    .s2(s2[k]),
    .power_out(bus.power_out),
    .power_valid(bus.power_valid),
    .power_bin(bus.power_bin),
    .power_last(bus.power_last)
  );
endmodule

// File: tb/tb_goertzel_bank.sv
// tb_goertzel_bank: randomized blocks against a block-level Goertzel model, with timing and reset checks
module tb_goertzel_bank;
  localparam int N = 4;
  localparam int FRAC = 23;
  typedef logic signed [127:0] w_t;
  typedef struct { logic [63:0] p; int bin; bit last; int cyc; } exp_t;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic signed [25:0] sh [N];
  logic signed [25:0] act [N];
  logic [63:0] seen [N];
  int blk [$];
  exp_t q [$];
  exp_t e;
  int tb_cnt = 0;
  int lat = 0;
  int prev_acc = -1;
  bit prev_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  goertzel_bank_if #(.NUM_BINS(N)) bus ();
  goertzel_bank #(.NUM_BINS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic w_t fdiv(w_t a);
    w_t d = w_t'(1) <<< FRAC;
    return a < 0 ? -((-a + d - 1) / d) : a / d;
  endfunction

  function automatic logic [63:0] ref_pow(logic signed [25:0] c);
    w_t s1 = 0, s2 = 0, s0, p;
    w_t smax = (w_t'(1) <<< 47) - 1;
    w_t pmax = (w_t'(1) <<< 64) - 1;
    foreach (blk[i]) begin
      s0 = w_t'(blk[i]) + fdiv(w_t'(c) * s1) - s2;
      if (s0 > smax) s0 = smax;
      if (s0 < -smax - 1) s0 = -smax - 1;
      s2 = s1;
      s1 = s0;
    end
    p = s1 * s1 + s2 * s2 - fdiv(w_t'(c) * s1) * s2;
    if (p < 0) p = 0;
    if (p > pmax) p = pmax;
    return p[63:0];
  endfunction

  task automatic on_accept(int x, int len_req);
    if (tb_cnt == 0) begin
      act = sh;
      lat = len_req < 2 ? 2 : len_req > 1024 ? 1024 : len_req;
      blk.delete();
    end
    blk.push_back(x);
    tb_cnt++;
    if (tb_cnt == lat) begin
      for (int b = 0; b < N; b++) q.push_back('{ref_pow(act[b]), b, b == N - 1, cyc + N + 2 + b});
      tb_cnt = 0;
    end
  endtask

  task automatic send(int x, int len, bit we = 0, int addr = 0, logic signed [25:0] d = 0);
    int n = 0;
    bus.sample_valid = 1;
    bus.sample_in = 24'(x);
    bus.block_len = 11'(len);
    bus.coeff_we = we;
    bus.coeff_addr = 2'(addr);
    bus.coeff_wdata = d;
    @(negedge clk);
    while (!bus.sample_ready && n < 300) begin
      if (we) sh[addr] = d;
      n++;
      @(negedge clk);
    end
    if (!bus.sample_ready) chk("accept_timeout", 0, 1);
    else begin
      if (prev_acc >= 0) chk("accept_gap", cyc - prev_acc, prev_last ? 2 * N + 1 : N + 1);
      on_accept(x, len);
      if (we) sh[addr] = d;
      prev_acc = cyc;
      prev_last = tb_cnt == 0;
    end
    @(posedge clk);
    #1;
    bus.coeff_we = 0;
  endtask

  task automatic wr(int addr, logic signed [25:0] d);
    bus.coeff_we = 1;
    bus.coeff_addr = 2'(addr);
    bus.coeff_wdata = d;
    @(posedge clk);
    #1;
    sh[addr] = d;
    bus.coeff_we = 0;
  endtask

  task automatic pause();
    bus.sample_valid = 0;
    prev_acc = -1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_ready && n < 100);
    chk("idle_reached", bus.sample_ready, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_sample();
    case ($urandom_range(0, 2))
      0: return int'($urandom_range(0, 200)) - 100;
      1: return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 16777215)) - 8388608;
    endcase
  endfunction

  function automatic logic signed [25:0] rnd_coeff();
    return 26'(int'($urandom_range(0, 33554432)) - 16777216);
  endfunction

  always @(negedge clk)
    if (bus.power_valid) begin
      if (q.size() == 0) chk("unexpected_power_valid", 1, 0);
      else begin
        e = q.pop_front();
        seen[e.bin] = bus.power_out;
        chk("power_out", bus.power_out, e.p);
        chk("power_bin", bus.power_bin, e.bin);
        chk("power_last", bus.power_last, e.last);
        chk("power_cycle", cyc, e.cyc);
      end
    end

  initial begin
    int len, n;
    bus.sample_valid = 0;
    bus.sample_in = 0;
    bus.block_len = 0;
    bus.coeff_we = 0;
    bus.coeff_addr = 0;
    bus.coeff_wdata = 0;
    foreach (sh[i]) sh[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", bus.sample_ready, 0);
    chk("busy_in_reset", bus.busy, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", bus.sample_ready, 1);
    chk("busy_after_reset", bus.busy, 0);
    chk("pvalid_after_reset", bus.power_valid, 0);
    chk("pout_after_reset", bus.power_out, 0);
    chk("pbin_after_reset", bus.power_bin, 0);
    chk("plast_after_reset", bus.power_last, 0);
    @(posedge clk);
    #1;
    send(1, 4);
    chk("busy_mid_block", bus.busy, 1);
    send(0, 4);
    send(-1, 4);
    send(0, 4);
    pause();
    drain();
    for (int b = 0; b < N; b++) chk("fs4_power", seen[b], 4);
    wr(0, 26'(1 << 24));
    send(1, 3);
    send(1, 3);
    send(1, 3);
    pause();
    drain();
    chk("dc_power", seen[0], 9);
    wait_idle();
    send(5, 2, 1, 0, -26'(1 << 24));
    send(7, 2, 1, 1, 26'(3 << 22));
    send(-3, 2);
    send(4, 2);
    for (int blkn = 0; blkn < 30; blkn++) begin
      len = $urandom_range(0, 10);
      n = len < 2 ? 2 : len;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) send(rnd_sample(), len, 1, $urandom_range(0, N - 1), rnd_coeff());
        else send(rnd_sample(), len);
      end
    end
    pause();
    drain();
    wr(0, 26'(1 << 24));
    wr(1, 26'(33554431));
    wr(2, -26'(33554432));
    wr(3, rnd_coeff());
    for (int i = 0; i < 1024; i++) send(8388607, 2000);
    pause();
    drain();
    send(rnd_sample(), 2);
    send(rnd_sample(), 2);
    pause();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.power_valid && bus.power_bin == 2'd1) && n < 50);
    chk("reached_power_bin1", bus.power_valid && bus.power_bin == 2'd1, 1);
    #1;
    reset = 1;
    q.delete();
    tb_cnt = 0;
    foreach (sh[i]) sh[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_reset_in_power", bus.busy, 0);
    chk("ready_reset_in_power", bus.sample_ready, 0);
    @(posedge clk);
    #1;
    reset = 0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(rnd_sample(), 3);
    pause();
    drain();
    wr(2, rnd_coeff());
    for (int i = 0; i < 5; i++) send(rnd_sample(), 5);
    pause();
    drain();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
